// File: rtl/state_remap_pkg.sv
// Shared definitions for the state-code remapper: legacy decoder map,
// table entry type and the reset-image builder.
package state_remap_pkg;

  // Widest code the reset builder produces; tables slice it down to OUT_W.
  localparam int CODE_MAX_W = 32;

  // Legacy fixed decoder: state 1..9 -> these codes, everything else unmapped.
  localparam int LEGACY_N = 9;
  localparam logic [3:0] LEGACY_CODE [LEGACY_N] =
    '{4'd5, 4'd4, 4'd3, 4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8};

  typedef struct packed {
    logic                  en;
    logic [CODE_MAX_W-1:0] code;
  } map_entry_t;

  // Reset contents of table entry idx; callers evaluate it for every
  // index 0..2**IN_W-1 and keep the low OUT_W code bits.
  function automatic map_entry_t build_reset_entry(input int idx);
    map_entry_t e;
    e.en   = 1'b0;
    e.code = '0;
    if (idx >= 1 && idx <= LEGACY_N) begin
      e.en   = 1'b1;
      e.code = CODE_MAX_W'(LEGACY_CODE[idx-1]);
    end
    return e;
  endfunction

endpackage

// File: rtl/state_remap_table.sv
// Lookup table for state_remap: register array with one write port and an
// asynchronous read port. Reset reloads the legacy mapping.
module remap_table
  import state_remap_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IN_W-1:0]  waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic             wen,
  input  logic [IN_W-1:0]  raddr,
  output logic [OUT_W-1:0] rcode,
  output logic             ren
);

  localparam int DEPTH = 2**IN_W;

  logic [OUT_W-1:0] r_code [DEPTH];
  logic [DEPTH-1:0] r_en;

  logic [OUT_W-1:0] w_rst_code [DEPTH];
  logic [DEPTH-1:0] w_rst_en;

  // Constant reset image, one entry per table slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rst
    localparam map_entry_t E = build_reset_entry(gi);
    assign w_rst_code[gi] = E.code[OUT_W-1:0];
    assign w_rst_en[gi]   = E.en;
  end

  // Table storage: reset load has priority, so writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= w_rst_code;
      r_en   <= w_rst_en;
    end else if (we) begin
      r_code[waddr] <= wdata;
      r_en[waddr]   <= wen;
    end
  end

  // Read is asynchronous, so a same-cycle write is only seen by later lookups.
  assign rcode = r_code[raddr];
  assign ren   = r_en[raddr];

endmodule

// File: rtl/state_remap.sv
// Registered state-code remapper: one-deep valid/ready stage around a
// programmable lookup table, with miss reporting (sticky flag + counter).
module state_remap
  import state_remap_pkg::*;
#(
  parameter int             IN_W         = 4,
  parameter int             OUT_W        = 4,
  parameter int             CNT_W        = 8,
  parameter bit             HOLD_ON_MISS = 1'b1,
  parameter logic [OUT_W-1:0] MISS_CODE  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_code,
  output logic             out_hit,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             cfg_en,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_code;
  logic             r_out_hit;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_err;

  logic             w_accept;
  logic             w_in_ready;
  logic [OUT_W-1:0] w_tab_code;
  logic             w_tab_en;
  logic             w_miss;
  logic [OUT_W-1:0] w_miss_code;

  remap_table #(.IN_W(IN_W), .OUT_W(OUT_W)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .wen   (cfg_en),
    .raddr (in_code),
    .rcode (w_tab_code),
    .ren   (w_tab_en)
  );

  // Ready depends only on the output register state, never on in_valid.
  assign w_in_ready  = !r_out_valid || out_ready;
  assign w_accept    = in_valid && w_in_ready;
  assign w_miss      = w_accept && !w_tab_en;
  assign w_miss_code = HOLD_ON_MISS ? r_out_code : MISS_CODE;

  // Output stage: load on accept, drain when consumed, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_hit   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_code  <= w_tab_en ? w_tab_code : w_miss_code;
      r_out_hit   <= w_tab_en;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Miss tracking: a miss beats a same-cycle clear, restarting the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_miss_cnt <= '0;
    end else if (w_miss) begin
      r_err <= 1'b1;
      if (err_clr)                  r_miss_cnt <= CNT_W'(1);
      else if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_miss_cnt <= '0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign out_hit   = r_out_hit;
  assign miss_cnt  = r_miss_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_state_remap.sv
// Directed bench for state_remap. Instance a: defaults (hold on miss,
// 8-bit counter). Instance b: CNT_W=2, MISS_CODE output on miss.
// Both share every input.
module tb_state_remap;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_code;
  logic       out_ready;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_data;
  logic       cfg_en;
  logic       err_clr;

  logic       a_in_ready, a_valid, a_hit, a_err;
  logic [3:0] a_code;
  logic [7:0] a_cnt;
  logic       b_in_ready, b_valid, b_hit, b_err;
  logic [3:0] b_code;
  logic [1:0] b_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  state_remap dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_code(in_code), .out_valid(a_valid), .out_ready(out_ready),
    .out_code(a_code), .out_hit(a_hit), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .miss_cnt(a_cnt), .err(a_err),
    .err_clr(err_clr)
  );

  state_remap #(.CNT_W(2), .HOLD_ON_MISS(1'b0), .MISS_CODE(4'hF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .out_valid(b_valid), .out_ready(out_ready),
    .out_code(b_code), .out_hit(b_hit), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .miss_cnt(b_cnt), .err(b_err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] legacy [10];

  initial begin
    legacy = '{4'd0, 4'd5, 4'd4, 4'd3, 4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8};
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_en = 1'b0; err_clr = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_valid", a_valid, 0);
    chk("rst_code",  a_code,  0);
    chk("rst_hit",   a_hit,   0);
    chk("rst_cnt",   a_cnt,   0);
    chk("rst_err",   a_err,   0);
    chk("rst_ready", a_in_ready, 1);
    rst = 1'b0;
    tick();

    // legacy map streamed at full rate
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_code = 4'(i);
      tick();
      chk($sformatf("map%0d_valid", i), a_valid, 1);
      chk($sformatf("map%0d_code", i),  a_code,  legacy[i]);
      chk($sformatf("map%0d_hit", i),   a_hit,   1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", a_valid, 0);
    chk("drain_code",  a_code,  8);

    // hit then miss: a holds, b emits MISS_CODE
    in_valid = 1'b1; in_code = 4'd3;
    tick();
    chk("hit3_code", a_code, 3);
    in_code = 4'd12;
    tick();
    chk("miss12_code", a_code, 3);
    chk("miss12_hit",  a_hit,  0);
    chk("miss12_err",  a_err,  1);
    chk("miss12_cnt",  a_cnt,  1);
    chk("b_miss_code", b_code, 4'hF);
    chk("b_miss_hit",  b_hit,  0);

    // clear alone
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", a_err, 0);
    chk("clr_cnt", a_cnt, 0);

    // stall: pending input must not be lost or duplicated
    in_valid = 1'b1; in_code = 4'd5;
    tick();
    chk("pre_stall_code", a_code, 1);
    out_ready = 1'b0; in_code = 4'd6;
    #1;
    chk("stall_ready0", a_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_ready", k), a_in_ready, 0);
      chk($sformatf("stall%0d_code", k),  a_code,     1);
      chk($sformatf("stall%0d_valid", k), a_valid,    1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", a_in_ready, 1);
    tick();
    chk("release_code",  a_code,  2);
    chk("release_valid", a_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("release_drain", a_valid, 0);
    chk("release_hold",  a_code,  2);

    // same-cycle write and lookup: read-before-write
    in_valid = 1'b1; in_code = 4'd4;
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 4'd9; cfg_en = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("rbw_old_code", a_code, 0);
    chk("rbw_old_hit",  a_hit,  1);
    tick();
    chk("rbw_new_code", a_code, 9);
    chk("b_rbw_new",    b_code, 9);

    // two misses, then miss together with clear: set wins, count restarts at 1
    in_code = 4'd0;
    tick(); tick();
    chk("two_miss_cnt", a_cnt, 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_miss_err", a_err, 1);
    chk("clr_miss_cnt", a_cnt, 1);
    chk("b_clr_miss_cnt", b_cnt, 1);

    // five more misses: b saturates at 3, a keeps counting and holds its code
    in_code = 4'd13;
    for (int k = 0; k < 5; k++) tick();
    chk("b_sat_cnt",  b_cnt,  3);
    chk("a_cnt6",     a_cnt,  6);
    chk("a_hold9",    a_code, 9);
    chk("b_miss_F",   b_code, 4'hF);
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("b_clr_cnt", b_cnt, 0);
    chk("b_clr_err", b_err, 0);

    // enabling a previously unmapped entry turns it into a hit
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 4'd7; cfg_en = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b1; in_code = 4'd12;
    tick();
    chk("new12_code", a_code, 7);
    chk("new12_hit",  a_hit,  1);

    // reset mid-stream with a write attempt: output discarded, write dropped
    in_code = 4'd1;
    tick();
    chk("pre_rst_code", b_code, 5);
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 4'd3; cfg_en = 1'b1;
    tick();
    chk("mid_rst_valid", b_valid, 0);
    chk("mid_rst_code",  a_code,  0);
    rst = 1'b0; cfg_we = 1'b0;
    tick();
    chk("post_rst_code1", a_code, 5);
    in_code = 4'd4;
    tick();
    chk("post_rst_code4", a_code, 0);
    in_code = 4'd12;
    tick();
    chk("post_rst_miss12", b_code, 4'hF);
    chk("post_rst_cnt",    a_cnt,  1);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
